// File: rtl/seq_trunc_divider_pkg.sv
// seq_trunc_divider_pkg: shared FSM states, default width and saturation helper for the divider.
package seq_trunc_divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_e;

    localparam int DEF_W = 8;

    function automatic logic [63:0] all_ones(input int w);
        return ~({64{1'b1}} << w);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// div_sub_stage: (W+1)-bit compare/subtract built as a ripple of mux-based full adders.
module div_sub_stage
    import seq_trunc_divider_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   a_i,
    input  logic [W:0]   b_i,
    output logic [W-1:0] diff_o,
    output logic         q_o
);

    logic [W+1:0] c;
    logic [W-1:0] s;

    assign c[0] = 1'b1;

    // a + ~b + 1: final carry set means a >= b; the top sum bit is always 0 when kept
    for (genvar i = 0; i <= W; i++) begin : g_fa
        logic p;
        assign p = a_i[i] ^ ~b_i[i];
        assign c[i+1] = p ? c[i] : a_i[i];
        if (i < W) begin : g_sum
            assign s[i] = c[i] ? ~p : p;
        end
    end

    assign q_o = c[W+1];
    assign diff_o = q_o ? s : a_i[W-1:0];

endmodule

// File: rtl/seq_trunc_divider.sv
// seq_trunc_divider: radix-2 restoring divider, 2W/W -> W quotient + W remainder, one bit per clock.
// Define SEQ_TRUNC_DIVIDER_ROUND_EN to add a round-to-nearest cycle after the last step.
module seq_trunc_divider
    import seq_trunc_divider_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] ONES = W'(all_ones(W));

    state_e state_q, state_d;
    logic [W-1:0] r_q, r_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [W-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic dbz_q, dbz_d, ovf_q, ovf_d;
    logic [W-1:0] diff;
    logic qb;
`ifdef SEQ_TRUNC_DIVIDER_ROUND_EN
    logic rnd;
`endif

    // lo_q shifts dividend bits out of its top while quotient bits enter at the bottom
    div_sub_stage #(.W(W)) u_sub (
        .a_i    ({r_q, lo_q[W-1]}),
        .b_i    ({1'b0, dvs_q}),
        .diff_o (diff),
        .q_o    (qb)
    );

    always_comb begin
        state_d = state_q;
        r_d = r_q;
        lo_d = lo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;
        ovf_d = ovf_q;
`ifdef SEQ_TRUNC_DIVIDER_ROUND_EN
        rnd = {r_q, 1'b0} >= {1'b0, dvs_q};
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                dvs_d = divisor;
                lo_d = dividend[W-1:0];
                r_d = dividend[2*W-1:W];
                cnt_d = CW'(W - 1);
                if (divisor == '0 || dividend[2*W-1:W] >= divisor) begin
                    state_d = DONE;
                    quo_d = ONES;
                    rem_d = '0;
                    dbz_d = divisor == '0;
                    ovf_d = divisor != '0;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d = diff;
                lo_d = {lo_q[W-2:0], qb};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
`ifdef SEQ_TRUNC_DIVIDER_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
                    quo_d = {lo_q[W-2:0], qb};
                    rem_d = diff;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
`endif
                end
            end
`ifdef SEQ_TRUNC_DIVIDER_ROUND_EN
            ROUND: begin
                state_d = DONE;
                quo_d = (rnd && lo_q != ONES) ? lo_q + 1'b1 : lo_q;
                rem_d = rnd ? dvs_q - r_q : r_q;
                dbz_d = 1'b0;
                ovf_d = 1'b0;
            end
`endif
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q <= '0;
            lo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q <= r_d;
            lo_q <= lo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dbz_q <= dbz_d;
            ovf_q <= ovf_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quotient = quo_q;
    assign remainder = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_trunc_divider.sv
// tb_seq_trunc_divider: directed vectors with a queue scoreboard checked by an output monitor.
module tb_seq_trunc_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, in_ready, out_valid, out_ready, div_by_zero, overflow;
    logic [15:0] dividend;
    logic [7:0] divisor, quotient, remainder;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic dbz;
        logic ovf;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int ov_cyc = 0;
    logic ov_prev = 1'b0;

`ifdef SEQ_TRUNC_DIVIDER_ROUND_EN
    localparam int LN = 10;
    localparam logic [7:0] Q1000 = 8'h8F;
    localparam logic [7:0] R1000 = 8'h01;
`else
    localparam int LN = 9;
    localparam logic [7:0] Q1000 = 8'h8E;
    localparam logic [7:0] R1000 = 8'h06;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_trunc_divider #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string n, input int a, input int x);
        tests++;
        if (a != x) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
        end
    endtask

    // monitor: timestamps the handshake and first valid cycle, pops on each result transfer
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) hs_cyc = cyc;
            if (out_valid && !ov_prev) ov_cyc = cyc;
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got q=0x%0h with empty scoreboard", quotient);
                end else begin
                    e = sb.pop_front();
                    chk("latency", ov_cyc - hs_cyc, e.lat);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("overflow", overflow, e.ovf);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] d, input logic [7:0] v, input logic [7:0] q,
                         input logic [7:0] r, input logic z, input logic o, input int lat,
                         input bit push);
        chk("idle_before_issue", in_ready, 1);
        if (push) sb.push_back(exp_t'{q, r, z, o, lat});
        dividend = d;
        divisor = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL timeout: out_valid got 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic take();
        wait_valid();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_drops", out_valid, 0);
        chk("ready_returns", in_ready, 1);
    endtask

    task automatic chk_cleared(input string n);
        chk({n, "_in_ready"}, in_ready, 1);
        chk({n, "_out_valid"}, out_valid, 0);
        chk({n, "_quotient"}, quotient, 0);
        chk({n, "_remainder"}, remainder, 0);
        chk({n, "_dbz"}, div_by_zero, 0);
        chk({n, "_ovf"}, overflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1 chk_cleared("reset");
        rst = 1'b0;
        issue(16'h3000, 8'h40, 8'hC0, 8'h00, 1'b0, 1'b0, LN, 1'b1);
        wait_valid();
        repeat (5) begin
            @(posedge clk);
            #1 chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", quotient, 8'hC0);
            chk("hold_remainder", remainder, 8'h00);
        end
        take();
        issue(16'h5400, 8'h60, 8'hE0, 8'h00, 1'b0, 1'b0, LN, 1'b1);
        dividend = 16'h0100;
        divisor = 8'h01;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 chk("calc_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        take();
        issue(16'h03E8, 8'h07, Q1000, R1000, 1'b0, 1'b0, LN, 1'b1);
        take();
        issue(16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1, 1'b1);
        take();
        issue(16'h4000, 8'h40, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1'b1);
        take();
        issue(16'h03E8, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_cleared("abort");
        issue(16'hFFFE, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 1'b1);
        take();
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
